// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between NREQ requesters.
// Operands are captured at grant and the result is registered, so the ALU
// sits between two register stages.
module alu_arbiter #(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned OP_W   = 4
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*OP_W-1:0]   req_aluop,
    input  logic [NREQ*WORD_W-1:0] req_porta,
    input  logic [NREQ*WORD_W-1:0] req_portb,
    output logic [NREQ-1:0]        rsp_valid,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic [WORD_W-1:0]      rsp_portout,
    output logic [2:0]             rsp_flags,
    output logic [OP_W-1:0]        alu_aluop,
    output logic [WORD_W-1:0]      alu_porta,
    output logic [WORD_W-1:0]      alu_portb,
    input  logic [WORD_W-1:0]      alu_portout,
    input  logic [2:0]             alu_flags,
    output logic                   busy
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned IW    = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   r_owner;
    logic [OP_W-1:0]    r_aluop;
    logic [WORD_W-1:0]  r_porta;
    logic [WORD_W-1:0]  r_portb;
    logic [WORD_W-1:0]  r_result;
    logic [2:0]         r_flags;

    logic               w_grant_found;
    logic [PTR_W-1:0]   w_grant;
    logic [PTR_W-1:0]   w_cand;
    logic [IW-1:0]      w_sum;
    logic [OP_W-1:0]    w_sel_aluop;
    logic [WORD_W-1:0]  w_sel_porta;
    logic [WORD_W-1:0]  w_sel_portb;
    logic [PTR_W-1:0]   w_owner_inc;
    logic               w_accept;
    logic               w_release;

    // Round-robin search: first valid requester at or after r_rr_ptr, wrapping.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant       = '0;
        w_sum         = '0;
        w_cand        = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_sum = IW'(r_rr_ptr) + IW'(k);
            if (w_sum >= IW'(NREQ)) begin
                w_sum = w_sum - IW'(NREQ);
            end
            w_cand = PTR_W'(w_sum);
            if (!w_grant_found && req_valid[w_cand]) begin
                w_grant_found = 1'b1;
                w_grant       = w_cand;
            end
        end
    end

    // Select the granted requester's opcode and operands.
    always_comb begin
        w_sel_aluop = '0;
        w_sel_porta = '0;
        w_sel_portb = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_grant == PTR_W'(i)) begin
                w_sel_aluop = req_aluop[i*OP_W +: OP_W];
                w_sel_porta = req_porta[i*WORD_W +: WORD_W];
                w_sel_portb = req_portb[i*WORD_W +: WORD_W];
            end
        end
    end

    assign w_owner_inc = (r_owner == PTR_W'(NREQ - 1)) ? '0 : PTR_W'(r_owner + PTR_W'(1));

    // Next-state and handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        rsp_valid   = '0;
        w_accept    = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_found) begin
                    req_ready[w_grant] = 1'b1;
                    w_accept           = 1'b1;
                    w_state_nxt        = EXEC;
                end
            end
            EXEC: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                rsp_valid[r_owner] = 1'b1;
                if (rsp_ready[r_owner]) begin
                    w_release   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture at grant, result capture in EXEC, pointer advance on release.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_aluop  <= '0;
            r_porta  <= '0;
            r_portb  <= '0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            if (w_accept) begin
                r_owner <= w_grant;
                r_aluop <= w_sel_aluop;
                r_porta <= w_sel_porta;
                r_portb <= w_sel_portb;
            end
            if (r_state == EXEC) begin
                r_result <= alu_portout;
                r_flags  <= alu_flags;
            end
            if (w_release) begin
                r_rr_ptr <= w_owner_inc;
            end
        end
    end

    assign alu_aluop   = r_aluop;
    assign alu_porta   = r_porta;
    assign alu_portb   = r_portb;
    assign rsp_portout = r_result;
    assign rsp_flags   = r_flags;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU on the alu_* side, constant vectors,
// hand-written corner sequences and a randomized run against a transaction model.
module tb_alu_arbiter;

    localparam int unsigned NREQ   = 2;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned OP_W   = 4;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;

    logic                   CLK = 1'b0;
    logic                   nRST;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*OP_W-1:0]   req_aluop;
    logic [NREQ*WORD_W-1:0] req_porta;
    logic [NREQ*WORD_W-1:0] req_portb;
    logic [NREQ-1:0]        rsp_valid;
    logic [NREQ-1:0]        rsp_ready;
    logic [WORD_W-1:0]      rsp_portout;
    logic [2:0]             rsp_flags;
    logic [OP_W-1:0]        alu_aluop;
    logic [WORD_W-1:0]      alu_porta;
    logic [WORD_W-1:0]      alu_portb;
    logic [WORD_W-1:0]      alu_portout;
    logic [2:0]             alu_flags;
    logic                   busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    alu_arbiter #(.NREQ(NREQ), .WORD_W(WORD_W), .OP_W(OP_W)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_aluop(req_aluop), .req_porta(req_porta), .req_portb(req_portb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_portout(rsp_portout), .rsp_flags(rsp_flags),
        .alu_aluop(alu_aluop), .alu_porta(alu_porta), .alu_portb(alu_portb),
        .alu_portout(alu_portout), .alu_flags(alu_flags),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Behavioural ALU: returns {negative, overflow, zero, result}.
    function automatic logic [34:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        ovf;
        ovf = 1'b0;
        case (op)
            OP_ADD: begin r = a + b; ovf = (a[31] == b[31]) && (r[31] != a[31]); end
            OP_SUB: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            default: r = a;
        endcase
        return {r[31], ovf, (r == 32'd0), r};
    endfunction

    always_comb {alu_flags, alu_portout} = alu_ref(alu_aluop, alu_porta, alu_portb);

    function automatic logic [NREQ-1:0] onehot(input int r);
        logic [NREQ-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int r, input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid[r]                  = v;
        req_aluop[r*OP_W +: OP_W]     = op;
        req_porta[r*WORD_W +: WORD_W] = a;
        req_portb[r*WORD_W +: WORD_W] = b;
    endtask

    // One transaction on an otherwise idle arbiter, rsp_ready already high.
    task automatic single_op(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_res, input logic [2:0] exp_flags, input string tag);
        int waited;
        waited = 0;
        set_req(r, 1'b1, op, a, b);
        settle();
        while (!req_ready[r] && waited < 20) begin
            step();
            settle();
            waited++;
        end
        chk({tag, " grant"}, req_ready, onehot(r));
        chk({tag, " busy_idle"}, busy, 1'b0);
        step();
        req_valid[r] = 1'b0;
        settle();
        chk({tag, " busy_exec"}, busy, 1'b1);
        chk({tag, " ready_exec"}, req_ready, '0);
        chk({tag, " rsp_exec"}, rsp_valid, '0);
        chk({tag, " alu_op"}, alu_aluop, op);
        chk({tag, " alu_a"}, alu_porta, a);
        chk({tag, " alu_b"}, alu_portb, b);
        step();
        settle();
        chk({tag, " rsp_valid"}, rsp_valid, onehot(r));
        chk({tag, " result"}, rsp_portout, exp_res);
        chk({tag, " flags"}, rsp_flags, exp_flags);
        chk({tag, " busy_resp"}, busy, 1'b1);
        step();
        settle();
        chk({tag, " busy_done"}, busy, 1'b0);
        chk({tag, " rsp_done"}, rsp_valid, '0);
    endtask

    // Transaction-level model: an active op responds from accept cycle + 2 until taken.
    logic        m_active;
    int          m_owner;
    int          m_t;
    int          m_rr;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b, m_res;
    logic [2:0]  m_flags;
    int          q_grants[$];

    task automatic model_reset();
        m_active = 1'b0; m_owner = 0; m_t = 0; m_rr = 0;
        m_op = '0; m_a = '0; m_b = '0; m_res = '0; m_flags = '0;
    endtask

    task automatic model_cycle();
        logic [NREQ-1:0] e_ready;
        logic [NREQ-1:0] e_rsp;
        int              g;
        int              idx;
        e_ready = '0;
        e_rsp   = '0;
        g       = -1;
        if (!m_active) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_rr + k) % NREQ;
                if (g < 0 && req_valid[idx]) g = idx;
            end
            if (g >= 0) e_ready[g] = 1'b1;
        end else if (cyc >= m_t + 2) begin
            e_rsp[m_owner] = 1'b1;
        end
        chk("m_req_ready", req_ready, e_ready);
        chk("m_rsp_valid", rsp_valid, e_rsp);
        chk("m_busy", busy, m_active);
        chk("m_alu_op", alu_aluop, m_op);
        chk("m_alu_a", alu_porta, m_a);
        chk("m_alu_b", alu_portb, m_b);
        if (e_rsp != '0) begin
            chk("m_result", rsp_portout, m_res);
            chk("m_flags", rsp_flags, m_flags);
        end
        if (!m_active && g >= 0) begin
            m_active = 1'b1;
            m_owner  = g;
            m_t      = cyc;
            m_op     = req_aluop[g*OP_W +: OP_W];
            m_a      = req_porta[g*WORD_W +: WORD_W];
            m_b      = req_portb[g*WORD_W +: WORD_W];
            {m_flags, m_res} = alu_ref(m_op, m_a, m_b);
            q_grants.push_back(g);
        end else if (m_active && cyc >= m_t + 2 && rsp_ready[m_owner]) begin
            m_active = 1'b0;
            m_rr     = (m_owner + 1) % NREQ;
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [2:0]  flags;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [NREQ-1:0] seen;
        int              nk[NREQ];
        int              iter;
        logic [31:0]     v;

        vecs[0] = '{OP_ADD, 32'd5,          32'd7,          32'd12,         3'b000};
        vecs[1] = '{OP_SUB, 32'd3,          32'd3,          32'd0,          3'b001};
        vecs[2] = '{OP_ADD, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  3'b110};
        vecs[3] = '{OP_SUB, 32'd0,          32'd1,          32'hFFFF_FFFF,  3'b100};
        vecs[4] = '{OP_SUB, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  3'b010};
        vecs[5] = '{OP_AND, 32'h0000_F0F0,  32'h0000_0FF0,  32'h0000_00F0,  3'b000};
        vecs[6] = '{OP_OR,  32'd0,          32'd0,          32'd0,          3'b001};
        vecs[7] = '{OP_XOR, 32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  3'b100};
        vecs[8] = '{OP_ADD, 32'hFFFF_FFFF,  32'd1,          32'd0,          3'b001};

        // Reset values.
        nRST      = 1'b0;
        req_valid = '0;
        req_aluop = '0;
        req_porta = '0;
        req_portb = '0;
        rsp_ready = '1;
        step();
        step();
        chk("rst req_ready", req_ready, '0);
        chk("rst rsp_valid", rsp_valid, '0);
        chk("rst busy", busy, 1'b0);
        chk("rst alu_op", alu_aluop, '0);
        chk("rst alu_a", alu_porta, '0);
        chk("rst alu_b", alu_portb, '0);
        chk("rst result", rsp_portout, '0);
        chk("rst flags", rsp_flags, '0);
        nRST = 1'b1;

        // Constant vectors, alternating requesters.
        for (int i = 0; i < 9; i++) begin
            single_op(i % NREQ, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flags, $sformatf("vec%0d", i));
        end

        // Asynchronous reset in EXEC discards the op.
        set_req(0, 1'b1, OP_ADD, 32'h1234, 32'h1);
        settle();
        chk("rstx grant", req_ready, onehot(0));
        step();
        req_valid[0] = 1'b0;
        settle();
        chk("rstx exec a", alu_porta, 32'h1234);
        nRST = 1'b0;
        #1;
        chk("rstx rsp_valid", rsp_valid, '0);
        chk("rstx busy", busy, 1'b0);
        chk("rstx alu_a", alu_porta, '0);
        chk("rstx alu_op", alu_aluop, '0);
        step();
        settle();
        chk("rstx no_rsp", rsp_valid, '0);
        nRST = 1'b1;
        single_op(0, OP_ADD, 32'd5, 32'd7, 32'd12, 3'b000, "post_rst add");

        // Lone requester 1.
        single_op(1, OP_SUB, 32'd3, 32'd3, 32'd0, 3'b001, "req1 sub");

        // Backpressure on requester 0 while requester 1 waits.
        rsp_ready = 2'b10;
        set_req(0, 1'b1, OP_ADD, 32'd100, 32'd23);
        settle();
        chk("bp grant0", req_ready, onehot(0));
        step();
        req_valid[0] = 1'b0;
        set_req(1, 1'b1, OP_SUB, 32'd50, 32'd8);
        settle();
        chk("bp exec ready", req_ready, '0);
        step();
        settle();
        for (int c = 0; c < 10; c++) begin
            chk("bp rsp_valid", rsp_valid, onehot(0));
            chk("bp result", rsp_portout, 32'd123);
            chk("bp ready1", req_ready, '0);
            step();
            settle();
        end
        rsp_ready[0] = 1'b1;
        settle();
        chk("bp release rsp", rsp_valid, onehot(0));
        chk("bp release ready", req_ready, '0);
        step();
        settle();
        chk("bp grant1", req_ready, onehot(1));
        step();
        req_valid[1] = 1'b0;
        settle();
        step();
        settle();
        chk("bp rsp1", rsp_valid, onehot(1));
        chk("bp result1", rsp_portout, 32'd42);
        step();
        settle();
        chk("bp idle", busy, 1'b0);

        // Request withdrawn while another op sits in RESP.
        rsp_ready = '0;
        set_req(1, 1'b1, OP_OR, 32'hA, 32'h5);
        settle();
        chk("wd grant1", req_ready, onehot(1));
        step();
        req_valid[1] = 1'b0;
        settle();
        step();
        settle();
        chk("wd rsp1", rsp_valid, onehot(1));
        chk("wd result", rsp_portout, 32'hF);
        set_req(0, 1'b1, OP_ADD, 32'd1, 32'd1);
        settle();
        chk("wd ready0 resp", req_ready, '0);
        step();
        req_valid[0] = 1'b0;
        rsp_ready[1] = 1'b1;
        settle();
        chk("wd ready0 gone", req_ready, '0);
        step();
        settle();
        for (int c = 0; c < 5; c++) begin
            chk("wd idle busy", busy, 1'b0);
            chk("wd idle ready", req_ready, '0);
            chk("wd idle rsp", rsp_valid, '0);
            step();
            settle();
        end
        rsp_ready = '1;

        // Contention: both requesters valid from reset, four ADDs each.
        nRST = 1'b0;
        #1;
        model_reset();
        q_grants.delete();
        for (int r = 0; r < NREQ; r++) begin
            nk[r] = 0;
            set_req(r, 1'b1, OP_ADD, 32'(16 * r), 32'(16 * r));
        end
        step();
        nRST = 1'b1;
        iter = 0;
        while (iter < 80) begin
            settle();
            model_cycle();
            for (int r = 0; r < NREQ; r++) if (req_ready[r]) nk[r]++;
            if (nk[0] >= 4 && nk[1] >= 4 && !m_active) break;
            step();
            for (int r = 0; r < NREQ; r++) begin
                if (nk[r] < 4) begin
                    v = 32'(nk[r] + 16 * r);
                    set_req(r, 1'b1, OP_ADD, v, v);
                end else begin
                    req_valid[r] = 1'b0;
                end
            end
            iter++;
        end
        chk("cont finished", (iter < 80), 1'b1);
        chk("cont grants", q_grants.size(), 8);
        for (int j = 0; j < 8 && j < q_grants.size(); j++) begin
            chk($sformatf("cont order%0d", j), q_grants[j], j % 2);
        end
        step();
        req_valid = '0;

        // Randomized traffic against the model.
        nRST = 1'b0;
        #1;
        model_reset();
        seen = '0;
        step();
        nRST = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (req_valid[r] && !seen[r]) begin
                    if ($urandom_range(0, 15) == 0) req_valid[r] = 1'b0;
                end else if ($urandom_range(0, 1) == 1) begin
                    set_req(r, 1'b1, 4'($urandom_range(0, 5)),
                            ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom,
                            ($urandom_range(0, 3) == 0) ? 32'd1 : $urandom);
                end else begin
                    req_valid[r] = 1'b0;
                end
                rsp_ready[r] = ($urandom_range(0, 9) < 6);
            end
            settle();
            model_cycle();
            seen = req_ready;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
